tybec_stream_serializer: RTL and testbench
==========================================

# tybec_stream_serializer

Width adapter between the AXI4 read master's stream output and a scalar TyBEC kernel datapath. Accepts full-width memory words (512 bits) on a valid/ready stream and emits them as consecutive narrow elements (32 bits), lane 0 first, one element per cycle. It sits directly downstream of the read master, in the kernel clock domain, and feeds the generated functional top. It sustains one element per cycle with no bubble between words.

## Interface
- `C_DATA_WIDTH`, default 512: input word width; must be a multiple of `C_ELEM_WIDTH`.
- `C_ELEM_WIDTH`, default 32: output element width.
- `LP_NUM_LANES` (localparam) = `C_DATA_WIDTH/C_ELEM_WIDTH`; `LP_LANE_W` = `$clog2(LP_NUM_LANES)`.

Ports:
- `aclk`  in  1  sole clock (the kernel clock). One clock; reset is synchronous and active-high.
- `areset`  in  1  synchronous, active-high reset.
- `s_tvalid`  in  1  input word valid.
- `s_tready`  out  1  input word accepted when high together with `s_tvalid`.
- `s_tdata`  in  `C_DATA_WIDTH`  input word; lane k = bits `[k*C_ELEM_WIDTH +: C_ELEM_WIDTH]`.
- `s_tlast`  in  1  word is the last of the transfer.
- `m_tvalid`  out  1  element valid.
- `m_tready`  in  1  downstream accepts element.
- `m_tdata`  out  `C_ELEM_WIDTH`  current element.
- `m_tlane`  out  `LP_LANE_W`  lane index of current element.
- `m_tlast`  out  1  high only on the final lane of a word captured with `s_tlast=1`.
- `stat_elem_cnt`  out  32  number of elements accepted downstream since reset; wraps modulo 2^32.

## Operation
- FSM states:
  - EMPTY: no word is held.
  - FULL: a word is held in `word_q`, with `lane_q` pointing at the current lane and `last_q` holding the captured `s_tlast`.
- `s_tready` = (state==EMPTY) || (lane_q==LP_NUM_LANES-1 && m_tready). This reload path allows back-to-back words.
- EMPTY, on `s_tvalid`: capture the word, set lane_q=0, capture last_q, go to FULL.
- FULL, on `m_tvalid && m_tready`:
  - If lane_q < N-1: increment lane_q.
  - Else, if an input handshake happens in the same cycle: reload the new word, set lane_q=0, stay in FULL.
  - Else: go to EMPTY.
- `m_tvalid` = (state==FULL). `m_tdata` = lane `lane_q` of `word_q`. `m_tlane` = lane_q. `m_tlast` = last_q && lane_q==N-1.
- `m_tdata`/`m_tlane` must hold stable while `m_tvalid && !m_tready`. The AXI-stream rule applies: valid never depends on ready.
- `stat_elem_cnt` increments on every output handshake.

## Timing
- Reset values: state=EMPTY, `s_tready`=1, `m_tvalid`=0, `m_tdata`=0, `m_tlane`=0, `m_tlast`=0, `stat_elem_cnt`=0.
- Latency: element 0 is valid on the cycle after the input handshake (registered output).
- Throughput: 1 element/cycle under continuous `m_tready`. One word is accepted every N cycles, with zero idle cycles between the last lane of one word and lane 0 of the next.
- Backpressure: with `m_tready`=0, `s_tready`=0 whenever state is FULL.
- Reset asserted mid-word: the held word is discarded, with no partial output after reset. The next output comes only from a newly accepted word.
- `stat_elem_cnt` wraps from 0xFFFFFFFF to 0.

## Structure
- A shared package `tybec_stream_pkg` holds:
  - the `state_t` enum (EMPTY, FULL);
  - the lane-count and width helper functions shared with the matching deserializer on the write side.
- No sub-module is needed.
- The lane mux is an indexed part-select. Shifting `word_q` right by `C_ELEM_WIDTH` per handshake is an acceptable alternative; with that choice, `m_tdata` is bits `[C_ELEM_WIDTH-1:0]`.

## Test plan
- Reset, then one word with lanes 0x00..0x0F and `s_tlast`=1, `m_tready`=1 → 16 elements 0x0..0xF on consecutive cycles; `m_tlane` goes 0..15; `m_tlast` is high only on lane 15; `stat_elem_cnt`=16.
- Four back-to-back words, continuous ready → 64 consecutive valid cycles with no gap; `s_tready` pulses exactly on each lane-15 cycle.
- Random `m_tready` (50%) over 100 words → output sequence matches the reference unpacking; `m_tdata` stays stable during every stall; no element is lost or duplicated.
- `m_tready` held low for 20 cycles mid-word (lane 7) → `m_tdata` = lane 7 throughout; `s_tready`=0; resumes at lane 7.
- `areset` pulsed while at lane 5 → next cycle `m_tvalid`=0 and `stat_elem_cnt`=0; the next word starts at lane 0.
- `stat_elem_cnt` preloaded near wrap (force 0xFFFFFFFE), then 3 elements → count reads 0x1.

Source files
------------

// File: rtl/tybec_stream_pkg.sv
// Shared definitions for the TyBEC stream width adapters (serializer and deserializer).
package tybec_stream_pkg;

    // Two-state holding FSM; plain constants keep the encoding visible to older tools.
    typedef logic [0:0] state_t;
    localparam state_t EMPTY = 1'b0;
    localparam state_t FULL  = 1'b1;

    // Number of narrow lanes carried by one wide word.
    function automatic int unsigned num_lanes(input int unsigned data_w, input int unsigned elem_w);
        return data_w / elem_w;
    endfunction

    // Width of a lane index; never narrower than one bit so ports stay legal.
    function automatic int unsigned lane_width(input int unsigned data_w, input int unsigned elem_w);
        int unsigned n;
        n = data_w / elem_w;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tybec_stream_serializer_if.sv
// Generic valid/ready stream bundle used on both sides of the width adapters.
interface tybec_stream_serializer_if #(
    parameter int unsigned DataW = 32
);
    logic             tvalid;
    logic             tready;
    logic [DataW-1:0] tdata;
    logic             tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/tybec_stream_serializer.sv
// Wide-to-narrow stream adapter: holds one memory word and emits its lanes, lane 0 first.
module tybec_stream_serializer
    import tybec_stream_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH = 512,
    parameter int unsigned C_ELEM_WIDTH = 32,
    localparam int unsigned LP_NUM_LANES = num_lanes(C_DATA_WIDTH, C_ELEM_WIDTH),
    localparam int unsigned LP_LANE_W    = lane_width(C_DATA_WIDTH, C_ELEM_WIDTH)
) (
    input  logic                     aclk,
    input  logic                     areset,
    tybec_stream_serializer_if.slave  s,
    tybec_stream_serializer_if.master m,
    output logic [LP_LANE_W-1:0]     m_tlane,
    output logic [31:0]              stat_elem_cnt
);

    localparam logic [LP_LANE_W-1:0] LaneLast = LP_LANE_W'(LP_NUM_LANES - 1);

    state_t                                    state_q, state_d;
    logic [LP_NUM_LANES-1:0][C_ELEM_WIDTH-1:0] word_q, word_d;
    logic [LP_LANE_W-1:0]                      lane_q, lane_d;
    logic                                      last_q, last_d;
    logic [31:0]                               cnt_q, cnt_d;

    logic lane_at_last;
    logic s_ready;
    logic s_hs;
    logic m_hs;

    // Handshake decode; the reload path lets a new word in while the last lane drains.
    always_comb begin
        lane_at_last = (lane_q == LaneLast);
        s_ready      = (state_q == EMPTY) || (lane_at_last && m.tready);
        s_hs         = s.tvalid && s_ready;
        m_hs         = (state_q == FULL) && m.tready;
    end

    // Next-state: capture, advance lane, reload back-to-back, or fall empty.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        lane_d  = lane_q;
        last_d  = last_q;
        cnt_d   = cnt_q + 32'(m_hs);
        case (state_q)
            EMPTY: begin
                if (s_hs) begin
                    word_d  = s.tdata;
                    lane_d  = '0;
                    last_d  = s.tlast;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (m_hs) begin
                    if (!lane_at_last) begin
                        lane_d = lane_q + LP_LANE_W'(1);
                    end else if (s_hs) begin
                        word_d = s.tdata;
                        lane_d = '0;
                        last_d = s.tlast;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State registers; reset discards any held word so nothing partial leaks out.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= EMPTY;
            word_q  <= '0;
            lane_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s.tready      = s_ready;
    assign m.tvalid      = (state_q == FULL);
    assign m.tdata       = word_q[lane_q];
    assign m.tlast       = last_q && lane_at_last;
    assign m_tlane       = lane_q;
    assign stat_elem_cnt = cnt_q;

endmodule

// File: tb/tb_tybec_stream_serializer.sv
// Bench for tybec_stream_serializer: directed table, corner sequences and a random scoreboard run.
module tb_tybec_stream_serializer;

    localparam int DW = 512;
    localparam int EW = 32;
    localparam int NL = DW / EW;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  m_tlane;
    logic [31:0] stat;

    tybec_stream_serializer_if #(.DataW(DW)) in_if ();
    tybec_stream_serializer_if #(.DataW(EW)) out_if ();

    tybec_stream_serializer #(
        .C_DATA_WIDTH(DW),
        .C_ELEM_WIDTH(EW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s            (in_if),
        .m            (out_if),
        .m_tlane      (m_tlane),
        .stat_elem_cnt(stat)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: every accepted word becomes NL expected elements in a FIFO.
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  lane;
        logic        last;
    } elem_t;

    elem_t exp_q[$];
    logic  prv_stall = 1'b0;
    elem_t prv;

    always @(negedge aclk) begin
        elem_t e;
        elem_t cur;
        cur.data = out_if.tdata;
        cur.lane = m_tlane;
        cur.last = out_if.tlast;
        if (areset) begin
            exp_q.delete();
            prv_stall = 1'b0;
        end else begin
            if (prv_stall) begin
                chk("stall_valid", 64'(out_if.tvalid), 64'd1);
                chk("stall_hold", 64'(cur), 64'(prv));
            end
            if (out_if.tvalid && out_if.tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got element %0h with no expected element", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_elem", 64'(cur), 64'(e));
                end
            end
            if (in_if.tvalid && in_if.tready) begin
                for (int k = 0; k < NL; k++) begin
                    e.data = in_if.tdata[k*EW +: EW];
                    e.lane = 4'(k);
                    e.last = in_if.tlast && (k == NL - 1);
                    exp_q.push_back(e);
                end
            end
            prv_stall = out_if.tvalid && !out_if.tready;
            prv       = cur;
        end
    end

    // All control below runs in the phase just after a rising edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic load_word(input logic [DW-1:0] w, input logic last);
        bit hs;
        bit done;
        done         = 1'b0;
        in_if.tdata  = w;
        in_if.tlast  = last;
        in_if.tvalid = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge aclk);
            hs = in_if.tvalid && in_if.tready;
            step();
            if (hs) done = 1'b1;
        end
        in_if.tvalid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got no s_tready within 200 cycles, required a handshake");
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || out_if.tvalid) && c < max_cycles) begin
            step();
            c++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < NL; k++) w[k*EW +: EW] = $urandom;
        return w;
    endfunction

    // Streams n random words; reports output valid count/span and s_tready behaviour.
    task automatic run_words(input int n, input bit rnd, input int max_cycles,
                             output int valid_cnt, output int span,
                             output int pulses, output int bad);
        int  idx;
        int  cyc;
        int  first;
        int  last_v;
        bit  hs;
        idx = 0; cyc = 0; first = -1; last_v = -1;
        valid_cnt = 0; pulses = 0; bad = 0;
        in_if.tdata  = rand_word();
        in_if.tlast  = 1'($urandom_range(0, 1));
        in_if.tvalid = 1'b1;
        if (!rnd) out_if.tready = 1'b1;
        while ((idx < n || exp_q.size() != 0) && cyc < max_cycles) begin
            if (rnd) out_if.tready = 1'($urandom_range(0, 1));
            @(negedge aclk);
            hs = in_if.tvalid && in_if.tready;
            if (out_if.tvalid) begin
                valid_cnt++;
                if (first < 0) first = cyc;
                last_v = cyc;
                if (in_if.tready) pulses++;
                if (in_if.tready != (m_tlane == 4'(NL - 1) && out_if.tready)) bad++;
            end
            step();
            if (hs) begin
                idx++;
                if (idx < n) begin
                    in_if.tdata = rand_word();
                    in_if.tlast = 1'($urandom_range(0, 1));
                end else begin
                    in_if.tvalid = 1'b0;
                end
            end
            cyc++;
        end
        in_if.tvalid  = 1'b0;
        out_if.tready = 1'b1;
        span = (first < 0) ? 0 : last_v - first + 1;
        if (cyc >= max_cycles) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got %0d of %0d words done, required all", idx, n);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [3:0]  lane;
        logic        last;
    } vec_t;

    vec_t vecs[NL];

    initial begin
        logic [DW-1:0] w;
        int vc, sp, pu, bd;

        for (int k = 0; k < NL; k++) begin
            vecs[k].data = 32'(k);
            vecs[k].lane = 4'(k);
            vecs[k].last = (k == NL - 1);
        end

        areset        = 1'b1;
        in_if.tvalid  = 1'b0;
        in_if.tdata   = '0;
        in_if.tlast   = 1'b0;
        out_if.tready = 1'b0;
        repeat (3) step();
        @(negedge aclk);
        chk("rst_s_tready", 64'(in_if.tready), 64'd1);
        chk("rst_m_tvalid", 64'(out_if.tvalid), 64'd0);
        chk("rst_m_tdata", 64'(out_if.tdata), 64'd0);
        chk("rst_m_tlane", 64'(m_tlane), 64'd0);
        chk("rst_m_tlast", 64'(out_if.tlast), 64'd0);
        chk("rst_cnt", 64'(stat), 64'd0);
        step();
        areset = 1'b0;

        // One word, lanes 0..15, tlast set, continuous ready.
        for (int k = 0; k < NL; k++) w[k*EW +: EW] = 32'(k);
        out_if.tready = 1'b1;
        load_word(w, 1'b1);
        for (int k = 0; k < NL; k++) begin
            @(negedge aclk);
            chk("t1_valid", 64'(out_if.tvalid), 64'd1);
            chk("t1_data", 64'(out_if.tdata), 64'(vecs[k].data));
            chk("t1_lane", 64'(m_tlane), 64'(vecs[k].lane));
            chk("t1_last", 64'(out_if.tlast), 64'(vecs[k].last));
        end
        @(negedge aclk);
        chk("t1_idle", 64'(out_if.tvalid), 64'd0);
        chk("t1_cnt", 64'(stat), 64'd16);
        step();

        // Four back-to-back words with continuous ready.
        run_words(4, 1'b0, 200, vc, sp, pu, bd);
        chk("t2_valid_cnt", 64'(vc), 64'd64);
        chk("t2_span", 64'(sp), 64'd64);
        chk("t2_sready_pulses", 64'(pu), 64'd4);
        chk("t2_sready_bad", 64'(bd), 64'd0);
        chk("t2_cnt", 64'(stat), 64'd80);

        // 100 words under random ready; scoreboard checks order, stalls and loss.
        run_words(100, 1'b1, 8000, vc, sp, pu, bd);
        chk("t3_valid_ready_rule", 64'(bd), 64'd0);
        wait_drain(100);
        chk("t3_cnt", 64'(stat), 64'd1680);

        // Twenty-cycle stall parked on lane 7.
        w = rand_word();
        out_if.tready = 1'b1;
        load_word(w, 1'b0);
        repeat (7) step();
        out_if.tready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            chk("t4_data", 64'(out_if.tdata), 64'(w[7*EW +: EW]));
            chk("t4_lane", 64'(m_tlane), 64'd7);
            chk("t4_s_tready", 64'(in_if.tready), 64'd0);
        end
        step();
        out_if.tready = 1'b1;
        @(negedge aclk);
        chk("t4_resume_lane", 64'(m_tlane), 64'd7);
        step();
        wait_drain(100);

        // Reset while lane 5 is presented.
        w = rand_word();
        load_word(w, 1'b1);
        repeat (5) step();
        areset = 1'b1;
        step();
        areset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            chk("t5_valid", 64'(out_if.tvalid), 64'd0);
            chk("t5_cnt", 64'(stat), 64'd0);
        end
        step();
        w = rand_word();
        load_word(w, 1'b0);
        @(negedge aclk);
        chk("t5_lane0", 64'(m_tlane), 64'd0);
        chk("t5_data0", 64'(out_if.tdata), 64'(w[EW-1:0]));
        step();
        wait_drain(100);

        // Element counter wrap.
        force dut.cnt_q = 32'hFFFF_FFFE;
        step();
        release dut.cnt_q;
        out_if.tready = 1'b0;
        load_word(rand_word(), 1'b0);
        out_if.tready = 1'b1;
        repeat (3) step();
        out_if.tready = 1'b0;
        @(negedge aclk);
        chk("t6_wrap", 64'(stat), 64'd1);
        step();
        out_if.tready = 1'b1;
        wait_drain(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
